// File: rtl/physics_pkg.sv
// rtl/physics_pkg.sv - shared size constants and FSM state encoding for node_integrator
//
// Purpose: default sizes for the mass-node integrator, the accumulator guard width,
// and the integrator FSM state enum. Imported by node_integrator.
// Ports: none (package).

package physics_pkg;

   localparam int DEF_NUM_NODES     = 4;
   localparam int DEF_POSITION_SIZE = 8;
   localparam int DEF_VELOCITY_SIZE = 7;
   localparam int DEF_FORCE_SIZE    = 5;
   localparam int DEF_MASS_SHIFT    = 1;

   // Extra accumulator bits above FORCE_SIZE so several springs can pile up
   // before saturation kicks in.
   localparam int ACC_GUARD_BITS    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed saturating adder with independent operand and result widths
//
// Purpose: y = clamp(a + b) to the signed range of Y_W bits; never wraps.
// Ports:
//   a  input  A_W signed  first operand
//   b  input  B_W signed  second operand
//   y  output Y_W signed  saturated sum (Y_W must not exceed max(A_W,B_W)+1)

module sat_add #(
   parameter int A_W = 8,
   parameter int B_W = 8,
   parameter int Y_W = 8
) (
   input  logic signed [A_W-1:0] a,
   input  logic signed [B_W-1:0] b,
   output logic signed [Y_W-1:0] y
);

   // One bit wider than the wider operand so the raw sum can never overflow.
   localparam int S_W = ((A_W > B_W) ? A_W : B_W) + 1;
   localparam logic signed [S_W-1:0] Y_MAX = S_W'((2 ** (Y_W - 1)) - 1);
   localparam logic signed [S_W-1:0] Y_MIN = S_W'(-(2 ** (Y_W - 1)));

   logic signed [S_W-1:0] sum;

   always_comb begin
      sum = S_W'(a) + S_W'(b);
      if (sum > Y_MAX) begin
         y = Y_MAX[Y_W-1:0];
      end else if (sum < Y_MIN) begin
         y = Y_MIN[Y_W-1:0];
      end else begin
         y = sum[Y_W-1:0];
      end
   end

endmodule

// File: rtl/node_integrator.sv
// rtl/node_integrator.sv - spring-mass node integrator: force accumulation and Euler pass
//
// Purpose: accumulates spring forces per node while idle, then on step_in walks
// every node once (one per cycle) applying v' = sat(v + (acc >>> MASS_SHIFT)),
// p' = sat(p + v'), clearing the accumulator, and pulses done.
// Optional feature macro: NODE_INTEGRATOR_GRAVITY_EN adds parameter GRAVITY,
// subtracted from each node's net y force before the mass shift.
// Ports:
//   clk_in, rst_in                  clock, synchronous active-high reset
//   force_valid/force_ready         spring-result handshake (ready only when idle)
//   force_x, force_y                force on node_a; node_b receives the negation
//   node_a, node_b                  spring endpoint indices
//   load_valid, load_node,
//   load_pos_x, load_pos_y          initial placement (velocity/accumulator zeroed)
//   step_in                         pulse to start an integration pass
//   busy, done                      pass in progress / one-cycle completion pulse
//   rd_node -> rd_pos_*, rd_vel_*   combinational state read

module node_integrator
   import physics_pkg::*;
#(
   parameter int NUM_NODES     = DEF_NUM_NODES,
   parameter int POSITION_SIZE = DEF_POSITION_SIZE,
   parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
   parameter int FORCE_SIZE    = DEF_FORCE_SIZE,
`ifdef NODE_INTEGRATOR_GRAVITY_EN
   parameter int GRAVITY       = 1,
`endif
   parameter int MASS_SHIFT    = DEF_MASS_SHIFT
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              force_valid,
   output logic                              force_ready,
   input  logic signed [FORCE_SIZE-1:0]      force_x,
   input  logic signed [FORCE_SIZE-1:0]      force_y,
   input  logic [$clog2(NUM_NODES)-1:0]      node_a,
   input  logic [$clog2(NUM_NODES)-1:0]      node_b,
   input  logic                              load_valid,
   input  logic [$clog2(NUM_NODES)-1:0]      load_node,
   input  logic signed [POSITION_SIZE-1:0]   load_pos_x,
   input  logic signed [POSITION_SIZE-1:0]   load_pos_y,
   input  logic                              step_in,
   output logic                              busy,
   output logic                              done,
   input  logic [$clog2(NUM_NODES)-1:0]      rd_node,
   output logic signed [POSITION_SIZE-1:0]   rd_pos_x,
   output logic signed [POSITION_SIZE-1:0]   rd_pos_y,
   output logic signed [VELOCITY_SIZE-1:0]   rd_vel_x,
   output logic signed [VELOCITY_SIZE-1:0]   rd_vel_y
);

   localparam int IW = $clog2(NUM_NODES);
   localparam int PW = POSITION_SIZE;
   localparam int VW = VELOCITY_SIZE;
   localparam int AW = FORCE_SIZE + ACC_GUARD_BITS;
   localparam int NW = AW + 1;           // net force: room for the gravity subtraction
   localparam int CW = FORCE_SIZE + 1;   // negated force: -min needs one more bit

   state_t         state, state_nx;
   logic [IW-1:0]  idx;

   logic signed [PW-1:0] pos_x [NUM_NODES];
   logic signed [PW-1:0] pos_y [NUM_NODES];
   logic signed [VW-1:0] vel_x [NUM_NODES];
   logic signed [VW-1:0] vel_y [NUM_NODES];
   logic signed [AW-1:0] acc_x [NUM_NODES];
   logic signed [AW-1:0] acc_y [NUM_NODES];
   logic signed [AW-1:0] acc_x_nx [NUM_NODES];
   logic signed [AW-1:0] acc_y_nx [NUM_NODES];

   logic                 force_fire;
   logic signed [CW-1:0] fx_ext, fy_ext;
   logic signed [NW-1:0] net_x, net_y;
   logic signed [VW-1:0] vel_x_new, vel_y_new;
   logic signed [PW-1:0] pos_x_new, pos_y_new;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Handshake/status outputs are gated by rst_in so they read 0 in the reset cycle.
   always_comb begin
      state_nx    = state;
      force_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            force_ready = !rst_in;
            if (step_in) state_nx = UPDATE;
         end
         UPDATE: begin
            busy = !rst_in;
            if (idx == IW'(NUM_NODES - 1)) state_nx = DONE;
         end
         DONE: begin
            busy     = !rst_in;
            done     = !rst_in;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- force accumulation ----------------
   assign force_fire = force_valid && force_ready;
   assign fx_ext     = CW'(force_x);
   assign fy_ext     = CW'(force_y);

   for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
      logic signed [CW-1:0] cx, cy;

      // A self-spring (node_a == node_b) cancels out, so it contributes nothing.
      always_comb begin
         cx = '0;
         cy = '0;
         if (force_fire && (node_a != node_b)) begin
            if (node_a == IW'(n)) begin
               cx = fx_ext;
               cy = fy_ext;
            end else if (node_b == IW'(n)) begin
               cx = -fx_ext;
               cy = -fy_ext;
            end
         end
      end

      sat_add #(.A_W(AW), .B_W(CW), .Y_W(AW)) u_acc_x (.a(acc_x[n]), .b(cx), .y(acc_x_nx[n]));
      sat_add #(.A_W(AW), .B_W(CW), .Y_W(AW)) u_acc_y (.a(acc_y[n]), .b(cy), .y(acc_y_nx[n]));
   end

   // ---------------- integration datapath (one node per cycle) ----------------
   assign net_x = NW'(acc_x[idx]) >>> MASS_SHIFT;
`ifdef NODE_INTEGRATOR_GRAVITY_EN
   assign net_y = (NW'(acc_y[idx]) - NW'(GRAVITY)) >>> MASS_SHIFT;
`else
   assign net_y = NW'(acc_y[idx]) >>> MASS_SHIFT;
`endif

   sat_add #(.A_W(VW), .B_W(NW), .Y_W(VW)) u_vel_x (.a(vel_x[idx]), .b(net_x), .y(vel_x_new));
   sat_add #(.A_W(VW), .B_W(NW), .Y_W(VW)) u_vel_y (.a(vel_y[idx]), .b(net_y), .y(vel_y_new));
   sat_add #(.A_W(PW), .B_W(VW), .Y_W(PW)) u_pos_x (.a(pos_x[idx]), .b(vel_x_new), .y(pos_x_new));
   sat_add #(.A_W(PW), .B_W(VW), .Y_W(PW)) u_pos_y (.a(pos_y[idx]), .b(vel_y_new), .y(pos_y_new));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         idx <= '0;
         for (int i = 0; i < NUM_NODES; i++) begin
            pos_x[i] <= '0;
            pos_y[i] <= '0;
            vel_x[i] <= '0;
            vel_y[i] <= '0;
            acc_x[i] <= '0;
            acc_y[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               idx <= '0;
               for (int i = 0; i < NUM_NODES; i++) begin
                  acc_x[i] <= acc_x_nx[i];
                  acc_y[i] <= acc_y_nx[i];
                  // Load overrides this node's share of a same-cycle force.
                  if (load_valid && (load_node == IW'(i))) begin
                     pos_x[i] <= load_pos_x;
                     pos_y[i] <= load_pos_y;
                     vel_x[i] <= '0;
                     vel_y[i] <= '0;
                     acc_x[i] <= '0;
                     acc_y[i] <= '0;
                  end
               end
            end
            UPDATE: begin
               vel_x[idx] <= vel_x_new;
               vel_y[idx] <= vel_y_new;
               pos_x[idx] <= pos_x_new;
               pos_y[idx] <= pos_y_new;
               acc_x[idx] <= '0;
               acc_y[idx] <= '0;
               idx        <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   assign rd_pos_x = pos_x[rd_node];
   assign rd_pos_y = pos_y[rd_node];
   assign rd_vel_x = vel_x[rd_node];
   assign rd_vel_y = vel_y[rd_node];

endmodule

// File: tb/tb_node_integrator.sv
// tb/tb_node_integrator.sv - scoreboard bench for node_integrator against a behavioural model

module tb_node_integrator;

   localparam int NN = 4;
   localparam int PW = 8;
   localparam int VW = 7;
   localparam int FW = 5;
   localparam int S  = 1;
   localparam int AW = FW + 4;
   localparam int IW = $clog2(NN);
`ifdef NODE_INTEGRATOR_GRAVITY_EN
   localparam int G = 1;
`else
   localparam int G = 0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_in = 1'b1;
   logic                 force_valid = 1'b0;
   logic                 force_ready;
   logic signed [FW-1:0] force_x = '0;
   logic signed [FW-1:0] force_y = '0;
   logic [IW-1:0]        node_a = '0;
   logic [IW-1:0]        node_b = '0;
   logic                 load_valid = 1'b0;
   logic [IW-1:0]        load_node = '0;
   logic signed [PW-1:0] load_pos_x = '0;
   logic signed [PW-1:0] load_pos_y = '0;
   logic                 step_in = 1'b0;
   logic                 busy;
   logic                 done;
   logic [IW-1:0]        rd_node = '0;
   logic signed [PW-1:0] rd_pos_x, rd_pos_y;
   logic signed [VW-1:0] rd_vel_x, rd_vel_y;

   node_integrator #(
      .NUM_NODES(NN), .POSITION_SIZE(PW), .VELOCITY_SIZE(VW),
      .FORCE_SIZE(FW), .MASS_SHIFT(S)
   ) dut (
      .clk_in(clk), .rst_in(rst_in),
      .force_valid(force_valid), .force_ready(force_ready),
      .force_x(force_x), .force_y(force_y), .node_a(node_a), .node_b(node_b),
      .load_valid(load_valid), .load_node(load_node),
      .load_pos_x(load_pos_x), .load_pos_y(load_pos_y),
      .step_in(step_in), .busy(busy), .done(done),
      .rd_node(rd_node), .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y),
      .rd_vel_x(rd_vel_x), .rd_vel_y(rd_vel_y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   int   exp_q[$];
   logic snap_req = 1'b0;
   logic end_req  = 1'b0;
   logic mon_done = 1'b0;

   // ---------------- reference model ----------------
   int m_px[NN], m_py[NN], m_vx[NN], m_vy[NN], m_ax[NN], m_ay[NN];

   function automatic int sat(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NN; i++) begin
         m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
      end
   endtask

   task automatic model_force(input int fx, input int fy, input int a, input int b);
      if (a != b) begin
         m_ax[a] = sat(m_ax[a] + fx, AW);
         m_ay[a] = sat(m_ay[a] + fy, AW);
         m_ax[b] = sat(m_ax[b] - fx, AW);
         m_ay[b] = sat(m_ay[b] - fy, AW);
      end
   endtask

   task automatic model_load(input int n, input int x, input int y);
      m_px[n] = x; m_py[n] = y;
      m_vx[n] = 0; m_vy[n] = 0; m_ax[n] = 0; m_ay[n] = 0;
   endtask

   task automatic model_step();
      for (int i = 0; i < NN; i++) begin
         m_vx[i] = sat(m_vx[i] + (m_ax[i] >>> S), VW);
         m_vy[i] = sat(m_vy[i] + ((m_ay[i] - G) >>> S), VW);
         m_px[i] = sat(m_px[i] + m_vx[i], PW);
         m_py[i] = sat(m_py[i] + m_vy[i], PW);
         m_ax[i] = 0;
         m_ay[i] = 0;
      end
   endtask

   // Record layout: cycle (-1 = any), ready, busy, done, then px,py,vx,vy per node.
   task automatic push_rec(input int e_cyc, input int rdy, input int bsy, input int dn);
      exp_q.push_back(e_cyc);
      exp_q.push_back(rdy);
      exp_q.push_back(bsy);
      exp_q.push_back(dn);
      for (int i = 0; i < NN; i++) begin
         exp_q.push_back(m_px[i]);
         exp_q.push_back(m_py[i]);
         exp_q.push_back(m_vx[i]);
         exp_q.push_back(m_vy[i]);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic cmp(input string name, input int n, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s node=%0d cycle=%0d: got %0d expected %0d", name, n, cyc, act, exp_v);
      end
   endtask

   initial begin
      int e_cyc, e_rdy, e_bsy, e_dn;
      forever begin
         @(negedge clk);
         if (done || snap_req) begin
            if (exp_q.size() < 4 + 4 * NN) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event cycle=%0d: got done=%0b with no expected record", cyc, done);
            end else begin
               e_cyc = exp_q.pop_front();
               e_rdy = exp_q.pop_front();
               e_bsy = exp_q.pop_front();
               e_dn  = exp_q.pop_front();
               cmp("force_ready", -1, int'(force_ready), e_rdy);
               cmp("busy", -1, int'(busy), e_bsy);
               cmp("done", -1, int'(done), e_dn);
               if (e_cyc >= 0) cmp("done_cycle", -1, cyc, e_cyc);
               for (int n = 0; n < NN; n++) begin
                  rd_node = IW'(n);
                  #1;
                  cmp("pos_x", n, int'(rd_pos_x), exp_q.pop_front());
                  cmp("pos_y", n, int'(rd_pos_y), exp_q.pop_front());
                  cmp("vel_x", n, int'(rd_vel_x), exp_q.pop_front());
                  cmp("vel_y", n, int'(rd_vel_y), exp_q.pop_front());
               end
            end
         end
         if (end_req && !mon_done) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL leftover_records: got %0d queued entries expected 0", exp_q.size());
            end
            mon_done = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      force_valid = 1'b0;
      load_valid  = 1'b0;
      step_in     = 1'b0;
   endtask

   task automatic drive(input bit lv, input int ln, input int lx, input int ly,
                        input bit fv, input int fx, input int fy, input int a, input int b,
                        input bit st);
      load_valid  = lv;
      load_node   = IW'(ln);
      load_pos_x  = PW'(lx);
      load_pos_y  = PW'(ly);
      force_valid = fv;
      force_x     = FW'(fx);
      force_y     = FW'(fy);
      node_a      = IW'(a);
      node_b      = IW'(b);
      step_in     = st;
      if (fv) model_force(fx, fy, a, b);
      if (lv) model_load(ln, lx, ly);
      if (st) begin
         model_step();
         push_rec(cyc + NN + 1, 0, 1, 1);
      end
      tick();
      clear_in();
      if (st) repeat (NN + 2) tick();
   endtask

   function automatic int rnd_f();
      return int'($urandom_range(0, 31)) - 16;
   endfunction

   function automatic int rnd_p();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   function automatic int rnd_n();
      return int'($urandom_range(0, NN - 1));
   endfunction

   initial begin
      model_clear();
      clear_in();

      // Reset: outputs held low while rst_in is high, then ready in IDLE.
      rst_in = 1'b1;
      tick();
      push_rec(-1, 0, 0, 0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      rst_in   = 1'b0;
      push_rec(-1, 1, 0, 0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;

      // Basic opposite-force pair.
      drive(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 10, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0,  1, 0, 4, 0, 1, 0);
      drive(0, 0, 0, 0,  0, 0, 0, 0, 0, 1);

      // Velocity and position saturation.
      drive(1, 2, 120, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 1, 15, 0, 2, 3, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Load and force on the same cycle; self-spring ignored.
      drive(1, 1, 5, -5, 1, 3, 0, 0, 1, 0);
      drive(0, 0, 0, 0,  1, 9, 9, 2, 2, 0);
      drive(0, 0, 0, 0,  1, -16, -16, 3, 0, 1);

      // force_valid held across a pass: accepted once with the step, not during UPDATE/DONE.
      force_valid = 1'b1;
      force_x     = FW'(7);
      force_y     = FW'(-5);
      node_a      = IW'(1);
      node_b      = IW'(2);
      step_in     = 1'b1;
      model_force(7, -5, 1, 2);
      model_step();
      push_rec(cyc + NN + 1, 0, 1, 1);
      tick();
      step_in = 1'b0;
      repeat (NN + 1) tick();
      force_valid = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset during a pass: no done, everything cleared, ready again.
      step_in = 1'b1;
      tick();
      step_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      model_clear();
      push_rec(-1, 1, 0, 0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      repeat (NN + 3) tick();

      // Randomised traffic.
      for (int it = 0; it < 12; it++) begin
         int nf;
         nf = int'($urandom_range(0, 5));
         if ($urandom_range(0, 2) == 0) drive(1, rnd_n(), rnd_p(), rnd_p(), 0, 0, 0, 0, 0, 0);
         for (int f = 0; f < nf; f++) begin
            drive($urandom_range(0, 3) == 0, rnd_n(), rnd_p(), rnd_p(),
                  1, rnd_f(), rnd_f(), rnd_n(), rnd_n(), 0);
         end
         drive(0, 0, 0, 0, $urandom_range(0, 1) == 1, rnd_f(), rnd_f(), rnd_n(), rnd_n(), 1);
      end

      end_req = 1'b1;
      for (int w = 0; w < 20 && !mon_done; w++) tick();
      if (!mon_done) begin
         errors++;
         $display("FAIL monitor_timeout: got no completion expected completion within 20 cycles");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
